// File: rtl/dafx_gain_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// dafx_gain_ramp_ctrl
//
// Purpose:
//   Moves the gains applied to the mixer toward CPU-written targets by at most
//   cr_ramp_step per audio frame, which avoids zipper noise on gain changes.
//   One shared compare/add unit visits the slots round-robin, one slot per
//   clock, starting on each fs_strobe. Slot NR_OF_CHANNELS_P is the output
//   gain; slots 0..NR_OF_CHANNELS_P-1 are the mixer channel gains.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fs_strobe           one-cycle frame strobe
//   cr_target_gain      per-slot target gains
//   cr_ramp_step        maximum change per frame per slot
//   cr_bypass           1 = gains follow targets every cycle
//   cmd_clear_missed    one-cycle clear of sr_missed_strobes
//   gain_out            gains applied to the mixer
//   gain_valid          one-cycle pulse: frame update complete
//   sr_ramp_busy        per slot, gain_out != target
//   sr_all_settled      no slot busy
//   sr_missed_strobes   saturating count of dropped strobes
//   dbg_state           1 while the FSM is in UPDATE
//   dbg_pending         a strobe is queued behind the current frame
//
// Handshake: gain_valid is a pure one-cycle notification with no ready; the
// mixer may sample gain_out at any time, and gain_valid marks the first cycle
// in which every slot holds its value for the frame just processed.
// -----------------------------------------------------------------------------
module dafx_gain_ramp_ctrl #(
    parameter int NR_OF_CHANNELS_P = 3,
    parameter int GAIN_WIDTH_P     = 16,
    parameter int MISS_CNT_WIDTH_P = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          fs_strobe,
    input  logic [NR_OF_CHANNELS_P:0][GAIN_WIDTH_P-1:0]   cr_target_gain,
    input  logic [GAIN_WIDTH_P-1:0]                       cr_ramp_step,
    input  logic                                          cr_bypass,
    input  logic                                          cmd_clear_missed,
    output logic [NR_OF_CHANNELS_P:0][GAIN_WIDTH_P-1:0]   gain_out,
    output logic                                          gain_valid,
    output logic [NR_OF_CHANNELS_P:0]                     sr_ramp_busy,
    output logic                                          sr_all_settled,
    output logic [MISS_CNT_WIDTH_P-1:0]                   sr_missed_strobes,
    output logic                                          dbg_state,
    output logic                                          dbg_pending
);

    localparam int IDX_W = (NR_OF_CHANNELS_P > 0) ? $clog2(NR_OF_CHANNELS_P + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_OF_CHANNELS_P);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    state_t                                       state_q;
    logic [IDX_W-1:0]                             idx_q;
    logic                                         pending_q;
    logic [NR_OF_CHANNELS_P:0][GAIN_WIDTH_P-1:0]  gain_q;
    logic                                         gain_valid_q;
    logic [MISS_CNT_WIDTH_P-1:0]                  miss_q;

    // Shared step unit for the slot addressed by idx_q.
    logic [GAIN_WIDTH_P:0]   t_ext;
    logic [GAIN_WIDTH_P:0]   g_ext;
    logic [GAIN_WIDTH_P:0]   s_ext;
    logic [GAIN_WIDTH_P:0]   diff;
    logic [GAIN_WIDTH_P:0]   moved;
    logic [GAIN_WIDTH_P-1:0] slot_d;
    logic                    miss_inc;

    always_comb begin
        t_ext  = {1'b0, cr_target_gain[idx_q]};
        g_ext  = {1'b0, gain_q[idx_q]};
        s_ext  = {1'b0, cr_ramp_step};
        diff   = '0;
        moved  = '0;
        slot_d = gain_q[idx_q];
        if (t_ext >= g_ext) begin
            diff  = t_ext - g_ext;
            moved = g_ext + s_ext;
        end else begin
            diff  = g_ext - t_ext;
            moved = g_ext - s_ext;
        end
        // Within one step the target is taken exactly, so the move can never
        // overshoot; otherwise g+s < t (or g-s > t), so no wrap is possible.
        if (diff <= s_ext) begin
            slot_d = t_ext[GAIN_WIDTH_P-1:0];
        end else begin
            slot_d = moved[GAIN_WIDTH_P-1:0];
        end
    end

    // A strobe is lost only when one is already queued behind the running frame.
    assign miss_inc = !cr_bypass && (state_q == ST_UPDATE) && fs_strobe && pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            gain_q       <= '0;
            gain_valid_q <= 1'b0;
            miss_q       <= '0;
        end else begin
            gain_valid_q <= 1'b0;
            if (cr_bypass) begin
                gain_q       <= cr_target_gain;
                state_q      <= ST_IDLE;
                idx_q        <= '0;
                pending_q    <= 1'b0;
                gain_valid_q <= fs_strobe;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (fs_strobe || pending_q) begin
                            state_q   <= ST_UPDATE;
                            idx_q     <= '0;
                            pending_q <= 1'b0;
                        end
                    end
                    ST_UPDATE: begin
                        gain_q[idx_q] <= slot_d;
                        if (fs_strobe) begin
                            pending_q <= 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q      <= ST_IDLE;
                            idx_q        <= '0;
                            gain_valid_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end
                endcase
            end

            // Clear has priority over a simultaneous miss.
            if (cmd_clear_missed) begin
                miss_q <= '0;
            end else if (miss_inc && (miss_q != '1)) begin
                miss_q <= miss_q + MISS_CNT_WIDTH_P'(1);
            end
        end
    end

    always_comb begin
        sr_ramp_busy = '0;
        for (int k = 0; k <= NR_OF_CHANNELS_P; k++) begin
            sr_ramp_busy[k] = (gain_q[k] != cr_target_gain[k]);
        end
    end

    assign sr_all_settled    = ~|sr_ramp_busy;
    assign gain_out          = gain_q;
    assign gain_valid        = gain_valid_q;
    assign sr_missed_strobes = miss_q;
    assign dbg_state         = (state_q == ST_UPDATE);
    assign dbg_pending       = pending_q;

endmodule

// File: tb/tb_dafx_gain_ramp_ctrl.sv
module tb_dafx_gain_ramp_ctrl;

  localparam int N  = 3;
  localparam int NS = N + 1;
  localparam int W  = 16;
  localparam int MW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    fs_strobe = 1'b0;
  logic [NS-1:0][W-1:0]    cr_target_gain = '0;
  logic [W-1:0]            cr_ramp_step = '0;
  logic                    cr_bypass = 1'b0;
  logic                    cmd_clear_missed = 1'b0;
  logic [NS-1:0][W-1:0]    gain_out;
  logic                    gain_valid;
  logic [NS-1:0]           sr_ramp_busy;
  logic                    sr_all_settled;
  logic [MW-1:0]           sr_missed_strobes;
  logic                    dbg_state;
  logic                    dbg_pending;

  dafx_gain_ramp_ctrl #(
    .NR_OF_CHANNELS_P(N),
    .GAIN_WIDTH_P(W),
    .MISS_CNT_WIDTH_P(MW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fs_strobe(fs_strobe),
    .cr_target_gain(cr_target_gain),
    .cr_ramp_step(cr_ramp_step),
    .cr_bypass(cr_bypass),
    .cmd_clear_missed(cmd_clear_missed),
    .gain_out(gain_out),
    .gain_valid(gain_valid),
    .sr_ramp_busy(sr_ramp_busy),
    .sr_all_settled(sr_all_settled),
    .sr_missed_strobes(sr_missed_strobes),
    .dbg_state(dbg_state),
    .dbg_pending(dbg_pending)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic check_gains(input string name, input logic [NS-1:0][W-1:0] exp);
    for (int k = 0; k < NS; k++)
      check($sformatf("%s slot%0d", name, k), 32'(gain_out[k]), 32'(exp[k]));
  endtask

  function automatic logic [NS-1:0][W-1:0] mk4(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] c, input logic [W-1:0] d);
    logic [NS-1:0][W-1:0] v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  // Strobe in the current cycle T; returns the cycle offset of gain_valid (-1 if none).
  task automatic run_frame(output int lat);
    fs_strobe = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      fs_strobe = 1'b0;
      if (gain_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [NS-1:0][W-1:0] tgt;
    logic [W-1:0]         step;
    logic [NS-1:0][W-1:0] exp;
    logic [NS-1:0]        busy;
  } vec_t;

  vec_t vecs[12];

  // Strobes at T, T+1, T+2 (optionally clear at T+2); checks pending/miss/valid timing.
  task automatic collision(input string name, input logic clr, input logic [MW-1:0] exp_miss);
    logic [31:0] mask;
    mask = '0;
    fs_strobe = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (gain_valid) mask[c] = 1'b1;
      if (c == 1) begin
        check({name, " state T+1"}, 32'(dbg_state), 32'd1);
        check({name, " pending T+1"}, 32'(dbg_pending), 32'd0);
      end
      if (c == 2) check({name, " pending T+2"}, 32'(dbg_pending), 32'd1);
      if (c == 3) check({name, " missed T+3"}, 32'(sr_missed_strobes), 32'(exp_miss));
      fs_strobe = (c <= 2);
      cmd_clear_missed = clr && (c == 2);
    end
    check({name, " valid cycles"}, mask, 32'h0000_0420);
  endtask

  int lat;
  logic [31:0] mask;
  logic any_pend, any_valid;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // stimulus table: rows applied back to back, state carries across rows
    vecs[0]  = '{mk4(16'h1000, 16'h1000, 16'h1000, 16'h1000), 16'h0400, mk4(16'h0400, 16'h0400, 16'h0400, 16'h0400), 4'hF};
    vecs[1]  = '{mk4(16'h1000, 16'h1000, 16'h1000, 16'h1000), 16'h0400, mk4(16'h0800, 16'h0800, 16'h0800, 16'h0800), 4'hF};
    vecs[2]  = '{mk4(16'h1000, 16'h1000, 16'h1000, 16'h1000), 16'h0400, mk4(16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00), 4'hF};
    vecs[3]  = '{mk4(16'h1000, 16'h1000, 16'h1000, 16'h1000), 16'h0400, mk4(16'h1000, 16'h1000, 16'h1000, 16'h1000), 4'h0};
    vecs[4]  = '{mk4(16'h0300, 16'h1000, 16'h1000, 16'h1000), 16'h0600, mk4(16'h0A00, 16'h1000, 16'h1000, 16'h1000), 4'h1};
    vecs[5]  = '{mk4(16'h0300, 16'h1000, 16'h1000, 16'h1000), 16'h0600, mk4(16'h0400, 16'h1000, 16'h1000, 16'h1000), 4'h1};
    vecs[6]  = '{mk4(16'h0300, 16'h1000, 16'h1000, 16'h1000), 16'h0600, mk4(16'h0300, 16'h1000, 16'h1000, 16'h1000), 4'h0};
    vecs[7]  = '{mk4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'hFFFF, mk4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 4'h0};
    vecs[8]  = '{mk4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFF, mk4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 4'h0};
    vecs[9]  = '{mk4(16'h1234, 16'h1234, 16'h1234, 16'h1234), 16'h0000, mk4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 4'hF};
    vecs[10] = '{mk4(16'h1234, 16'h1234, 16'h1234, 16'h1234), 16'h0000, mk4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 4'hF};
    vecs[11] = '{mk4(16'h0010, 16'h8000, 16'hFFF0, 16'hFFFF), 16'h0100, mk4(16'hFEFF, 16'hFEFF, 16'hFFF0, 16'hFFFF), 4'h3};

    // reset state
    cr_target_gain = mk4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    idle(3);
    check("reset gains", 32'(gain_out), 32'd0);
    check("reset gain_valid", 32'(gain_valid), 32'd0);
    check("reset missed", 32'(sr_missed_strobes), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    check("reset pending", 32'(dbg_pending), 32'd0);
    check("reset busy", 32'(sr_ramp_busy), 32'hF);
    check("reset settled", 32'(sr_all_settled), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // table-driven frames
    for (int i = 0; i < 12; i++) begin
      cr_target_gain = vecs[i].tgt;
      cr_ramp_step   = vecs[i].step;
      run_frame(lat);
      check($sformatf("row%0d latency", i), 32'(lat), 32'd5);
      check_gains($sformatf("row%0d", i), vecs[i].exp);
      check($sformatf("row%0d busy", i), 32'(sr_ramp_busy), 32'(vecs[i].busy));
      check($sformatf("row%0d settled", i), 32'(sr_all_settled), 32'(vecs[i].busy == '0));
      check($sformatf("row%0d state idle", i), 32'(dbg_state), 32'd0);
      @(negedge clk);
      check($sformatf("row%0d valid pulse", i), 32'(gain_valid), 32'd0);
      idle(10);
    end

    // strobe collision, then clear coinciding with a miss
    collision("collide", 1'b0, 8'd1);
    idle(20);
    collision("collide_clr", 1'b1, 8'd0);
    idle(20);

    // strobe in the gain_valid cycle starts immediately
    mask = '0;
    any_pend = 1'b0;
    fs_strobe = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gain_valid) mask[c] = 1'b1;
      any_pend |= dbg_pending;
      fs_strobe = (c == 5);
    end
    check("valid-cycle strobe valids", mask, 32'h0000_0420);
    check("valid-cycle strobe pending", 32'(any_pend), 32'd0);
    check("valid-cycle strobe missed", 32'(sr_missed_strobes), 32'd0);
    idle(10);

    // bypass
    cr_bypass = 1'b1;
    cr_target_gain = mk4(16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD);
    @(negedge clk);
    check_gains("bypass", mk4(16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD));
    check("bypass busy", 32'(sr_ramp_busy), 32'd0);
    mask = '0;
    any_pend = 1'b0;
    fs_strobe = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (gain_valid) mask[c] = 1'b1;
      any_pend |= dbg_pending | dbg_state;
      fs_strobe = (c <= 2);
    end
    check("bypass valids", mask, 32'h0000_000E);
    check("bypass fsm quiet", 32'(any_pend), 32'd0);
    check("bypass missed", 32'(sr_missed_strobes), 32'd0);
    cr_bypass = 1'b0;
    cr_target_gain = '0;
    cr_ramp_step = 16'h1000;
    @(negedge clk);
    run_frame(lat);
    check("post-bypass latency", 32'(lat), 32'd5);
    check_gains("post-bypass f1", mk4(16'h9BCD, 16'h9BCD, 16'h9BCD, 16'h9BCD));
    idle(10);
    run_frame(lat);
    check_gains("post-bypass f2", mk4(16'h8BCD, 16'h8BCD, 16'h8BCD, 16'h8BCD));
    idle(10);

    // mid-frame target change: slot2 at T+1 (used), slot0 at T+2 (too late)
    lat = -1;
    fs_strobe = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      fs_strobe = 1'b0;
      if (gain_valid && lat < 0) lat = c;
      if (c == 1) cr_target_gain[2] = 16'hFFFF;
      if (c == 2) cr_target_gain[0] = 16'hFFFF;
    end
    check("midframe latency", 32'(lat), 32'd5);
    check_gains("midframe", mk4(16'h7BCD, 16'h7BCD, 16'h9BCD, 16'h7BCD));
    idle(10);

    // reset in the middle of a frame with a nonzero miss count
    cr_target_gain = mk4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    cr_ramp_step = 16'h0400;
    fs_strobe = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      fs_strobe = (c <= 2);
    end
    check("pre-reset missed", 32'(sr_missed_strobes), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset-mid gains", 32'(gain_out), 32'd0);
    check("reset-mid missed", 32'(sr_missed_strobes), 32'd0);
    check("reset-mid valid", 32'(gain_valid), 32'd0);
    check("reset-mid state", 32'(dbg_state), 32'd0);
    check("reset-mid pending", 32'(dbg_pending), 32'd0);
    any_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      any_valid |= gain_valid;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      any_valid |= gain_valid;
    end
    check("reset-mid no valid", 32'(any_valid), 32'd0);
    check("reset-mid gains held", 32'(gain_out), 32'd0);
    run_frame(lat);
    check("after-reset latency", 32'(lat), 32'd5);
    check_gains("after-reset", mk4(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
